// File: rtl/uart_rx_ctrl_if.sv
// Read-side bus of the UART RX controller: CPU register-read port plus streaming drain port.
// The master is the controller, which produces the bytes. The slave is the consumer, which issues requests and ready.
interface uart_rx_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  cpu_rd_req;
  logic                  cpu_rd_ack;
  logic [DATA_WIDTH-1:0] cpu_rd_data;
  logic                  cpu_rd_unf;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    input  cpu_rd_req, m_ready,
    output cpu_rd_ack, cpu_rd_data, cpu_rd_unf, m_data, m_valid
  );

  modport slave (
    output cpu_rd_req, m_ready,
    input  cpu_rd_ack, cpu_rd_data, cpu_rd_unf, m_data, m_valid
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// Sole reader of the UART RX FIFO: arbitrates CPU reads (priority) against the stream drain
// and raises threshold, character-timeout and sticky-error interrupts.
module uart_rx_ctrl #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned TIMEOUT_TICKS = 640
) (
  input  logic                  uart_clk,
  input  logic                  rst,
  input  logic                  sample_tick,
  input  logic                  rx_empty,
  input  logic [3:0]            rx_level,
  input  logic                  rx_active,
  input  logic                  frame_error,
  input  logic                  overrun_error,
  output logic                  rx_rd_en,
  input  logic [DATA_WIDTH-1:0] rx_rd_data,
  uart_rx_ctrl_if.master        bus,
  input  logic                  drain_en,
  input  logic [3:0]            trig_level,
  input  logic [2:0]            irq_en,
  input  logic                  err_clr,
  output logic                  err_status,
  output logic                  irq
);

  localparam int unsigned LVL_W = 4;
  localparam int unsigned CNT_W = $clog2(TIMEOUT_TICKS + 1);

  typedef enum logic [2:0] {IDLE, POP, CAP, CPU_ACK, STREAM} state_t;

  state_t            state;
  logic              own_cpu;
  logic [CNT_W-1:0]  to_cnt;
  logic              to_flag;
  logic [LVL_W-1:0]  trig_eff;
  logic              thr;
  logic              to_clr;

  // The pop is gated by the live empty flag, so an external flush in POP never pops an empty FIFO.
  assign rx_rd_en = (state == POP) && !rx_empty;

  assign trig_eff = (trig_level == LVL_W'(0)) ? LVL_W'(1) : trig_level;
  assign thr      = (rx_level >= trig_eff);
  assign to_clr   = rx_empty || rx_active || rx_rd_en;

  // Arbitration and read sequencing.
  always_ff @(posedge uart_clk) begin
    if (rst) begin
      state           <= IDLE;
      own_cpu         <= 1'b0;
      bus.cpu_rd_ack  <= 1'b0;
      bus.cpu_rd_data <= '0;
      bus.cpu_rd_unf  <= 1'b0;
      bus.m_valid     <= 1'b0;
      bus.m_data      <= '0;
    end else begin
      bus.cpu_rd_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_rd_req) begin
            own_cpu <= 1'b1;
            if (rx_empty) begin
              bus.cpu_rd_ack  <= 1'b1;
              bus.cpu_rd_data <= '0;
              bus.cpu_rd_unf  <= 1'b1;
              state           <= CPU_ACK;
            end else begin
              state <= POP;
            end
          end else if (drain_en && !rx_empty) begin
            own_cpu <= 1'b0;
            state   <= POP;
          end
        end
        POP: begin
          if (!rx_empty) begin
            state <= CAP;
          end else if (own_cpu) begin
            bus.cpu_rd_ack  <= 1'b1;
            bus.cpu_rd_data <= '0;
            bus.cpu_rd_unf  <= 1'b1;
            state           <= CPU_ACK;
          end else begin
            state <= IDLE;
          end
        end
        CAP: begin
          if (own_cpu) begin
            bus.cpu_rd_ack  <= 1'b1;
            bus.cpu_rd_data <= rx_rd_data;
            bus.cpu_rd_unf  <= 1'b0;
            state           <= CPU_ACK;
          end else begin
            bus.m_valid <= 1'b1;
            bus.m_data  <= rx_rd_data;
            state       <= STREAM;
          end
        end
        CPU_ACK: state <= IDLE;
        STREAM: begin
          if (bus.m_ready) begin
            bus.m_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Character timeout, sticky line error and the registered interrupt.
  always_ff @(posedge uart_clk) begin
    if (rst) begin
      to_cnt     <= '0;
      to_flag    <= 1'b0;
      err_status <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (to_clr) begin
        to_cnt  <= '0;
        to_flag <= 1'b0;
      end else if (sample_tick && (to_cnt != CNT_W'(TIMEOUT_TICKS))) begin
        to_cnt <= to_cnt + CNT_W'(1);
        if ((to_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT_TICKS)) begin
          to_flag <= 1'b1;
        end
      end

      if (frame_error || overrun_error) begin
        err_status <= 1'b1;
      end else if (err_clr) begin
        err_status <= 1'b0;
      end

      irq <= (irq_en[0] & thr) | (irq_en[1] & to_flag) | (irq_en[2] & err_status);
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl with a behavioural RX FIFO on the read side.
module tb_uart_rx_ctrl;
  localparam int unsigned DW = 8;

  logic          uart_clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_tick = 1'b0;
  logic          rx_empty;
  logic [3:0]    rx_level;
  logic          rx_active = 1'b0;
  logic          frame_error = 1'b0;
  logic          overrun_error = 1'b0;
  logic          rx_rd_en;
  logic [DW-1:0] rx_rd_data = '0;
  logic          drain_en = 1'b0;
  logic [3:0]    trig_level = 4'd4;
  logic [2:0]    irq_en = 3'b000;
  logic          err_clr = 1'b0;
  logic          err_status;
  logic          irq;

  uart_rx_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx_ctrl #(.DATA_WIDTH(DW), .TIMEOUT_TICKS(640)) dut (
    .uart_clk      (uart_clk),
    .rst           (rst),
    .sample_tick   (sample_tick),
    .rx_empty      (rx_empty),
    .rx_level      (rx_level),
    .rx_active     (rx_active),
    .frame_error   (frame_error),
    .overrun_error (overrun_error),
    .rx_rd_en      (rx_rd_en),
    .rx_rd_data    (rx_rd_data),
    .bus           (bus),
    .drain_en      (drain_en),
    .trig_level    (trig_level),
    .irq_en        (irq_en),
    .err_clr       (err_clr),
    .err_status    (err_status),
    .irq           (irq)
  );

  always #5 uart_clk = ~uart_clk;

  // Behavioural FIFO: write port driven by the bench, read data one cycle after rx_rd_en.
  logic [DW-1:0] mem [16];
  logic [3:0]    wp = '0, rp = '0, lvl = '0;
  logic          push = 1'b0;
  logic [DW-1:0] push_data = '0;

  always @(posedge uart_clk) begin
    if (push) begin
      mem[wp] <= push_data;
      wp      <= wp + 4'd1;
    end
    if (rx_rd_en) begin
      rx_rd_data <= mem[rp];
      rp         <= rp + 4'd1;
    end
    lvl <= lvl + {3'b0, push} - {3'b0, rx_rd_en};
  end

  assign rx_empty = (lvl == 4'd0);
  assign rx_level = lvl;

  logic [8:0] cpu_q [$];
  logic [7:0] str_q [$];
  logic [8:0] mon_c;
  logic [7:0] mon_s;
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard whenever the DUT delivers a byte.
  always @(negedge uart_clk) begin
    if (!rst) begin
      if (bus.cpu_rd_ack) begin
        if (cpu_q.size() == 0) chk("cpu_unexpected", 32'(cpu_q.size()), 32'd1);
        else begin
          mon_c = cpu_q.pop_front();
          chk("cpu_data", 32'(bus.cpu_rd_data), 32'(mon_c[7:0]));
          chk("cpu_unf", 32'(bus.cpu_rd_unf), 32'(mon_c[8]));
        end
      end
      if (bus.m_valid && bus.m_ready) begin
        if (str_q.size() == 0) chk("stream_unexpected", 32'(str_q.size()), 32'd1);
        else begin
          mon_s = str_q.pop_front();
          chk("stream_data", 32'(bus.m_data), 32'(mon_s));
        end
      end
      if (rx_rd_en) chk("pop_while_empty", 32'(rx_empty), 32'd0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge uart_clk);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    push_data = d;
    push      = 1'b1;
    cyc(1);
    push      = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] d, input logic u);
    int k;
    cpu_q.push_back({u, d});
    bus.cpu_rd_req = 1'b1;
    k = 0;
    do begin
      cyc(1);
      k++;
    end while (!bus.cpu_rd_ack && k < 20);
    chk("cpu_ack_seen", 32'(bus.cpu_rd_ack), 32'd1);
    bus.cpu_rd_req = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (str_q.size() != 0 && k < 100) begin
      cyc(1);
      k++;
    end
    chk("stream_drained", 32'(str_q.size()), 32'd0);
  endtask

  task automatic wait_mvalid();
    int k;
    k = 0;
    while (!bus.m_valid && k < 20) begin
      cyc(1);
      k++;
    end
    chk("m_valid_seen", 32'(bus.m_valid), 32'd1);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      sample_tick = 1'b1;
      cyc(1);
      sample_tick = 1'b0;
      cyc(1);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({rx_rd_en, bus.cpu_rd_ack, bus.cpu_rd_unf, bus.m_valid, err_status, irq,
                bus.cpu_rd_data, bus.m_data});
  endfunction

  logic [7:0] held;

  initial begin
    bus.cpu_rd_req = 1'b0;
    bus.m_ready    = 1'b0;
    cyc(2);
    chk("reset_outputs", outs(), 32'd0);
    rst = 1'b0;
    cyc(1);

    // Reset while a streamed byte is held
    drain_en = 1'b1;
    push_byte(8'h3C);
    str_q.push_back(8'h3C);
    wait_mvalid();
    chk("t1_mdata", 32'(bus.m_data), 32'h3C);
    rst      = 1'b1;
    drain_en = 1'b0;
    cyc(1);
    chk("t1_reset_c1", outs(), 32'd0);
    cyc(1);
    rst = 1'b0;
    chk("t1_reset_c2", outs(), 32'd0);
    str_q.delete();
    cyc(1);
    chk("t1_level", 32'(rx_level), 32'd0);
    chk("t1_post_outs", outs(), 32'd0);

    // CPU read latency, non-empty and empty
    bus.m_ready = 1'b1;
    push_byte(8'hA5);
    cpu_q.push_back({1'b0, 8'hA5});
    bus.cpu_rd_req = 1'b1;
    cyc(1);
    chk("t2_rden_t1", 32'(rx_rd_en), 32'd1);
    chk("t2_ack_t1", 32'(bus.cpu_rd_ack), 32'd0);
    cyc(1);
    chk("t2_rden_t2", 32'(rx_rd_en), 32'd0);
    chk("t2_ack_t2", 32'(bus.cpu_rd_ack), 32'd0);
    cyc(1);
    chk("t2_ack_t3", 32'(bus.cpu_rd_ack), 32'd1);
    chk("t2_data_t3", 32'(bus.cpu_rd_data), 32'hA5);
    bus.cpu_rd_req = 1'b0;
    cyc(1);
    chk("t2_ack_t4", 32'(bus.cpu_rd_ack), 32'd0);
    cpu_q.push_back({1'b1, 8'h00});
    bus.cpu_rd_req = 1'b1;
    cyc(1);
    chk("t2_empty_ack", 32'(bus.cpu_rd_ack), 32'd1);
    chk("t2_empty_unf", 32'(bus.cpu_rd_unf), 32'd1);
    chk("t2_empty_data", 32'(bus.cpu_rd_data), 32'd0);
    chk("t2_empty_rden", 32'(rx_rd_en), 32'd0);
    bus.cpu_rd_req = 1'b0;
    cyc(1);

    // Arbitration: CPU first, stream takes the rest in order
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    str_q.push_back(8'h22);
    str_q.push_back(8'h33);
    drain_en = 1'b1;
    cpu_read(8'h11, 1'b0);
    wait_drain();
    bus.m_ready = 1'b0;
    push_byte(8'h44);
    str_q.push_back(8'h44);
    push_byte(8'h55);
    str_q.push_back(8'h55);
    wait_mvalid();
    held = bus.m_data;
    chk("t3_held_byte", 32'(held), 32'h44);
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("t3_hold_valid", 32'(bus.m_valid), 32'd1);
      chk("t3_hold_data", 32'(bus.m_data), 32'(held));
    end
    chk("t3_no_extra_pop", 32'(rx_level), 32'd1);
    bus.m_ready = 1'b1;
    wait_drain();
    drain_en = 1'b0;
    cyc(2);

    // Threshold interrupt
    trig_level = 4'd4;
    irq_en     = 3'b001;
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    cyc(1);
    chk("t4_irq_lvl3", 32'(irq), 32'd0);
    push_byte(8'h04);
    chk("t4_level4", 32'(rx_level), 32'd4);
    chk("t4_irq_same_cycle", 32'(irq), 32'd0);
    cyc(1);
    chk("t4_irq_rise", 32'(irq), 32'd1);
    cpu_read(8'h01, 1'b0);
    chk("t4_irq_fall", 32'(irq), 32'd0);
    cpu_read(8'h02, 1'b0);
    cpu_read(8'h03, 1'b0);
    cpu_read(8'h04, 1'b0);
    trig_level = 4'd0;
    cyc(2);
    chk("t4_trig0_empty", 32'(irq), 32'd0);
    push_byte(8'h66);
    cyc(1);
    chk("t4_trig0_one", 32'(irq), 32'd1);
    cpu_read(8'h66, 1'b0);
    irq_en     = 3'b000;
    trig_level = 4'd4;
    cyc(2);

    // Character timeout
    irq_en = 3'b010;
    push_byte(8'h77);
    tick(639);
    chk("t5_irq_639", 32'(irq), 32'd0);
    cyc(3);
    chk("t5_irq_639_idle", 32'(irq), 32'd0);
    tick(1);
    chk("t5_irq_640", 32'(irq), 32'd1);
    cpu_read(8'h77, 1'b0);
    chk("t5_pop_clears", 32'(irq), 32'd0);
    push_byte(8'h88);
    tick(300);
    rx_active = 1'b1;
    cyc(1);
    rx_active = 1'b0;
    tick(639);
    chk("t5_restart_639", 32'(irq), 32'd0);
    cyc(2);
    chk("t5_restart_idle", 32'(irq), 32'd0);
    tick(1);
    chk("t5_restart_640", 32'(irq), 32'd1);
    cpu_read(8'h88, 1'b0);
    chk("t5_pop_clears2", 32'(irq), 32'd0);
    irq_en = 3'b000;
    cyc(2);

    // Sticky error
    irq_en      = 3'b100;
    frame_error = 1'b1;
    cyc(1);
    frame_error = 1'b0;
    chk("t6_err_set", 32'(err_status), 32'd1);
    cyc(1);
    chk("t6_err_irq", 32'(irq), 32'd1);
    err_clr     = 1'b1;
    frame_error = 1'b1;
    cyc(1);
    err_clr     = 1'b0;
    frame_error = 1'b0;
    chk("t6_set_wins", 32'(err_status), 32'd1);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    chk("t6_err_clear", 32'(err_status), 32'd0);
    cyc(1);
    chk("t6_irq_clear", 32'(irq), 32'd0);
    overrun_error = 1'b1;
    cyc(1);
    overrun_error = 1'b0;
    chk("t6_overrun_set", 32'(err_status), 32'd1);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    irq_en  = 3'b000;
    chk("t6_overrun_clear", 32'(err_status), 32'd0);

    cyc(2);
    chk("scoreboard_empty", 32'(cpu_q.size() + str_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
